// File: rtl/rc_selftest_ctrl.sv
// -----------------------------------------------------------------------------
// rc_selftest_ctrl
//
// Self-test sequencer for a two-input AND/OR combinational network
// (z = x AND y, w = x OR y). On a start request it walks the four input
// vectors 00, 01, 10, 11 onto rc_x/rc_y. Each vector is held for SETTLE cycles
// (APPLY). The network outputs are then compared against the truth table in
// a single CHECK cycle. Failing vectors are flagged in fail_vec and counted in
// err_count. When all four vectors are done the block parks in DONE, with
// done/pass asserted and the results held.
//
// Parameters
//   SETTLE     cycles each vector is held before it is checked. The legal
//              range is 1..15; zero is not supported.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high reset; has priority over everything
//   start      level; launches a run when sampled in IDLE or DONE
//   rc_x       x operand to the network   (registered)
//   rc_y       y operand to the network   (registered)
//   rc_z       z result from the network  (expected x AND y)
//   rc_w       w result from the network  (expected x OR y)
//   busy       high while a run is in progress (APPLY/CHECK)
//   done       high in DONE; held until the next run or reset
//   pass       done AND err_count == 0
//   err_count  number of failing vectors, 0..4
//   fail_vec   bit i set if vector i failed
// -----------------------------------------------------------------------------
module rc_selftest_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       rc_x,
  output logic       rc_y,
  input  logic       rc_z,
  input  logic       rc_w,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Settle counter value on the last APPLY cycle of a vector.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [2:0] err_count_q, err_count_d;
  logic       rc_x_q, rc_x_d;
  logic       rc_y_q, rc_y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  // Truth-table expectation for the vector currently applied.
  logic exp_z;
  logic exp_w;
  logic mismatch;

  assign exp_z = (idx_q == 2'd3);
  assign exp_w = (idx_q != 2'd0);

  // Case inequality makes an X or Z from the network count as a failure
  // instead of silently comparing equal.
  assign mismatch = (rc_z !== exp_z) || (rc_w !== exp_w);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A new run starts from a clean slate and discards the held results.
        if (start) begin
          state_d     = APPLY;
          idx_d       = 2'd0;
          cnt_d       = 4'd0;
          fail_vec_d  = 4'd0;
          err_count_d = 3'd0;
        end
      end

      APPLY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          fail_vec_d[idx_q] = 1'b1;
          // At most four increments per run, so three bits never wrap.
          err_count_d       = err_count_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    busy_d = (state_d == APPLY) || (state_d == CHECK);
    rc_x_d = busy_d & idx_d[1];
    rc_y_d = busy_d & idx_d[0];
    done_d = (state_d == DONE);
    pass_d = done_d && (err_count_d == 3'd0);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      fail_vec_q  <= 4'd0;
      err_count_q <= 3'd0;
      rc_x_q      <= 1'b0;
      rc_y_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
      rc_x_q      <= rc_x_d;
      rc_y_q      <= rc_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign rc_x      = rc_x_q;
  assign rc_y      = rc_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
